// File: rtl/rr_arb4.sv
// 4-requester round-robin arbiter with registered grant index, grant-valid flag,
// and a bounded grant tenure that force-releases with a one-cycle timeout pulse.
module rr_arb4 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic       tout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam bit HAS_LIMIT = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt, cnt_d;
  logic [1:0]       idx_d;
  logic             vld_d, tout_d;
  logic [1:0]       win, cand;
  logic             found;

  // Registered state and outputs; reset aborts any live grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= 2'b00;
      hold_cnt <= '0;
      gnt_idx  <= 2'b00;
      gnt_vld  <= 1'b0;
      tout     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      hold_cnt <= cnt_d;
      gnt_idx  <= idx_d;
      gnt_vld  <= vld_d;
      tout     <= tout_d;
    end
  end

  // Next-state, winner search and next-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = hold_cnt;
    idx_d   = gnt_idx;
    vld_d   = gnt_vld;
    tout_d  = 1'b0;
    win     = ptr_q;
    cand    = ptr_q;
    found   = 1'b0;

    // Scan from the farthest offset down so the closest set bit to ptr wins.
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        vld_d = 1'b0;
        if (found) begin
          state_d = GRANT;
          idx_d   = win;
          vld_d   = 1'b1;
          ptr_d   = win + 2'd1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!req[gnt_idx]) begin
          state_d = IDLE;
          vld_d   = 1'b0;
        end else if (HAS_LIMIT && (hold_cnt == HOLD_LAST)) begin
          state_d = IDLE;
          vld_d   = 1'b0;
          tout_d  = 1'b1;
        end else begin
          cnt_d = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/rr_arb4.md
Name: rr_arb4

Overview:
- 4-requester round-robin arbiter with a registered 2-bit grant index and a grant-valid flag.
- Sits directly upstream of the 2-to-4 one-hot decoder. gnt_idx drives the decoder's 2-bit select; the decoder's one-hot output gated by gnt_vld forms the per-requester grant lines.
- Enforces fairness and a bounded grant tenure so no requester can starve the others.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one grant may be held; 0 = unlimited.
- CNT_W, 4: width of the tenure counter; must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request vector; req[i] high = requester i wants or keeps the resource.
- gnt_idx  output  2  index of granted requester (feeds decoder select).
- gnt_vld  output  1  high while gnt_idx is a live grant.
- tout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk; reset port is rst.
- Reset values: state=IDLE, gnt_idx=2'b00, gnt_vld=0, tout=0, ptr=2'b00, hold_cnt=0. rst wins over every other event and aborts any active grant in the same edge.
- ptr is the highest-priority index. Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4 (wrap 3->0).
- IDLE state:
  - gnt_vld=0.
  - If req!=0, the winner W is the first set bit in search order. Next edge: state=GRANT, gnt_idx=W, gnt_vld=1, ptr=W+1 mod 4, hold_cnt=0.
  - If req==0, remain in IDLE; gnt_idx holds its last value.
- GRANT state, each cycle:
  - If req[gnt_idx]==0: release. Next edge: state=IDLE, gnt_vld=0.
  - Else if MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1: force release. Next edge: state=IDLE, gnt_vld=0, tout=1 for exactly one cycle.
  - Else: hold_cnt increments; gnt_idx and gnt_vld are unchanged.
- Latency:
  - Request to grant: 1 cycle (req seen in IDLE at edge N, gnt_vld high after edge N).
  - Release to next grant: gnt_vld is low for exactly 1 cycle (mandatory IDLE bubble). The decoder select is therefore never changed while gnt_vld=1.
- Grant tenure: max MAX_HOLD cycles with gnt_vld=1 per grant.
- Fairness: a force-released requester is lowest priority at the next arbitration, because ptr already points past it. If it is the only requester, it is re-granted after the 1-cycle bubble.
- Requests from non-granted indices during GRANT are ignored. They are not latched and are sampled again in IDLE.
- Simultaneous release and timeout on the same cycle: treated as a normal release, tout=0.
- gnt_idx changes only on the IDLE->GRANT edge.
- Outputs are fully registered; no combinational path from req to any output.

Test Plan:
- Reset mid-grant: requester 2 granted, assert rst for 1 cycle -> next edge gnt_vld=0, gnt_idx=0, tout=0, ptr=0; with req=4'b1111 afterwards, first grant is idx 0.
- Single request: after reset, req=4'b0100 at cycle 1, dropped at cycle 4 -> gnt_vld=1, gnt_idx=2 from cycle 2 to cycle 4 inclusive, gnt_vld=0 at cycle 5, tout never asserted.
- Round-robin rotation: req=4'b1111 held constant, each requester dropping its bit for 1 cycle after 2 cycles of grant -> grant order 0,1,2,3,0 with one gnt_vld=0 bubble between grants.
- Wrap-around priority: grant idx 3 released, then req=4'b1001 -> next grant idx 0 (ptr wrapped to 0), then idx 3.
- Timeout, MAX_HOLD=8: req=4'b0011 held high -> idx 0 gets exactly 8 cycles of gnt_vld, tout pulses 1 cycle, bubble, then idx 1 gets 8 cycles; alternation continues.
- Release on final tenure cycle: req[gnt_idx] drops on the cycle hold_cnt==7 -> gnt_vld falls, tout stays 0. With MAX_HOLD=0 and a request held 100 cycles, the grant is held 100 cycles with no tout.
